// File: rtl/i2c_master_write.sv
// Single-master I2C write initiator: START, address+W, ACK, one data byte, ACK, STOP.
// SDA/SCL are open-drain; every non-IDLE state spans four SCL quarters of CLK_DIV clocks.
module i2c_master_write #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    inout  wire        sda,
    inout  wire        scl
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic             ack_err_q, ack_err_d;
    logic             done_q, done_d;
    logic [7:0]       sh_q;
    logic [7:0]       data_q;

    logic load_addr, load_data, shift_en;
    logic quarter_end, slot_end, ack_sample;
    logic sda_low, scl_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
        end
    end

    // Shift register and latched byte carry no reset; they are always loaded on acceptance.
    always_ff @(posedge clk) begin
        if (load_addr) begin
            sh_q   <= {addr, 1'b0};
            data_q <= data;
        end else if (load_data) begin
            sh_q <= data_q;
        end else if (shift_en) begin
            sh_q <= {sh_q[6:0], 1'b0};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        ack_err_d   = ack_err_q;
        done_d      = 1'b0;
        load_addr   = 1'b0;
        load_data   = 1'b0;
        shift_en    = 1'b0;
        quarter_end = (cnt_q == CNT_MAX);
        slot_end    = quarter_end && (qtr_q == 2'd3);
        ack_sample  = quarter_end && (qtr_q == 2'd2);

        if (state_q != IDLE) begin
            if (quarter_end) begin
                cnt_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = START;
                    load_addr = 1'b1;
                    ack_err_d = 1'b0;
                    cnt_d     = '0;
                    qtr_d     = 2'd0;
                end
            end
            START: begin
                if (slot_end) begin
                    state_d = ADDR;
                    bit_d   = 3'd7;
                end
            end
            ADDR, DATA: begin
                if (slot_end) begin
                    if (bit_q == 3'd0) begin
                        state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
                    end else begin
                        bit_d    = bit_q - 3'd1;
                        shift_en = 1'b1;
                    end
                end
            end
            ADDR_ACK, DATA_ACK: begin
                if (ack_sample && sda) begin
                    ack_err_d = 1'b1;
                end
                // ack_err_q already holds this slot's sample by the time the slot ends.
                if (slot_end) begin
                    if (state_q == ADDR_ACK && !ack_err_q) begin
                        state_d   = DATA;
                        load_data = 1'b1;
                        bit_d     = 3'd7;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (slot_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sda_low = 1'b0;
        scl_low = 1'b0;
        case (state_q)
            START: sda_low = qtr_q[1];
            ADDR, DATA: begin
                scl_low = ~qtr_q[1];
                sda_low = ~sh_q[7];
            end
            ADDR_ACK, DATA_ACK: scl_low = ~qtr_q[1];
            STOP: begin
                scl_low = ~qtr_q[1];
                sda_low = (qtr_q != 2'd3);
            end
            default: begin
                sda_low = 1'b0;
                scl_low = 1'b0;
            end
        endcase
    end

    assign sda     = sda_low ? 1'b0 : 1'bz;
    assign scl     = scl_low ? 1'b0 : 1'bz;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_write.sv
// Bench for i2c_master_write: pulled-up buses, a slave model at 0x55, and a bit-slot scoreboard.
module tb_i2c_master_write;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic [6:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       busy_a, busy_b, done_a, done_b, ack_a, ack_b;
    wire        sda_a, scl_a, sda_b, scl_b;

    pullup (sda_a);
    pullup (scl_a);
    pullup (sda_b);
    pullup (scl_b);

    logic slave_drv = 1'b0;
    logic sel = 1'b0;
    logic nack_data = 1'b0;

    assign sda_a = (slave_drv && !sel) ? 1'b0 : 1'bz;
    assign sda_b = (slave_drv && sel) ? 1'b0 : 1'bz;

    i2c_master_write #(.CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .addr(addr_a), .data(data_a),
        .busy(busy_a), .done(done_a), .ack_err(ack_a), .sda(sda_a), .scl(scl_a)
    );

    i2c_master_write #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .addr(addr_b), .data(data_b),
        .busy(busy_b), .done(done_b), .ack_err(ack_b), .sda(sda_b), .scl(scl_b)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and slave model: samples the selected bus mid-cycle, commits a bit on SCL fall.
    logic       m_sda, m_scl, p_sda = 1'b1, p_scl = 1'b1, pend = 1'b0, have_pend = 1'b0;
    logic       in_frame = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int         bitcnt = 0, byte_idx = 0;
    int         start_cnt = 0, stop_cnt = 0, rise_n = 0, obs_n = 0;
    logic       obs_mem [0:511];
    int         rise_mem [0:511];

    always @(negedge clk) begin
        m_sda = sel ? sda_b : sda_a;
        m_scl = sel ? scl_b : scl_a;
        if (rst) begin
            slave_drv = 1'b0;
            in_frame  = 1'b0;
            have_pend = 1'b0;
        end else if (p_scl && m_scl && p_sda && !m_sda) begin
            start_cnt++;
            in_frame  = 1'b1;
            have_pend = 1'b0;
            bitcnt    = 0;
            byte_idx  = 0;
            slave_drv = 1'b0;
        end else if (p_scl && m_scl && !p_sda && m_sda) begin
            stop_cnt++;
            in_frame  = 1'b0;
            have_pend = 1'b0;
            slave_drv = 1'b0;
        end else if (!p_scl && m_scl) begin
            if (rise_n < 512) rise_mem[rise_n] = cyc;
            rise_n++;
            pend      = m_sda;
            have_pend = 1'b1;
        end else if (p_scl && !m_scl && in_frame && have_pend) begin
            have_pend = 1'b0;
            if (obs_n < 512) obs_mem[obs_n] = pend;
            obs_n++;
            cur_byte = {cur_byte[6:0], pend};
            bitcnt++;
            if (bitcnt == 8) begin
                slave_drv = (byte_idx == 0) ? (cur_byte == {7'h55, 1'b0}) : !nack_data;
            end else if (bitcnt == 9) begin
                slave_drv = 1'b0;
                bitcnt    = 0;
                byte_idx++;
            end
        end
        p_sda = m_sda;
        p_scl = m_scl;
    end

    logic exp_q [$];

    task automatic push_frame(input logic [6:0] a, input logic [7:0] d,
                              input logic a_nack, input logic d_nack);
        for (int i = 6; i >= 0; i--) exp_q.push_back(a[i]);
        exp_q.push_back(1'b0);
        exp_q.push_back(a_nack);
        if (!a_nack) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
            exp_q.push_back(d_nack);
        end
    endtask

    task automatic kick(input logic on_b, input logic [6:0] a, input logic [7:0] d);
        if (on_b) begin
            addr_b = a; data_b = d; start_b = 1'b1;
        end else begin
            addr_a = a; data_a = d; start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input logic on_b, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (on_b ? done_b : done_a) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        addr_a = 7'h00; addr_b = 7'h00; data_a = 8'h00; data_b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b required 0", done_a); end
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err got %b required 0", ack_a); end
        n_checks++; if (sda_a !== 1'b1 || scl_a !== 1'b1) begin n_fail++; $display("FAIL reset_bus got sda=%b scl=%b required 1 1", sda_a, scl_a); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b got %b required 0", busy_b); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got busy=%b done=%b required 0 0", busy_a, done_a); end
    endtask

    task automatic test_basic;
        int n, rd, ob, rb, s0, p0;
        logic e;
        sel = 1'b0; nack_data = 1'b0;
        ob = obs_n; rb = rise_n; s0 = start_cnt; p0 = stop_cnt;
        push_frame(7'h55, 8'hA5, 1'b0, 1'b0);
        kick(1'b0, 7'h55, 8'hA5);
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise got %b required 1", busy_a); end
        wait_done(1'b0, 400, n);
        n_checks++; if (n != 320) begin n_fail++; $display("FAIL basic_done_latency got %0d required 320", n); end
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL basic_ack_err got %b required 0", ack_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done got %b required 0", busy_a); end
        rd = ob;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rd >= obs_n) begin n_fail++; $display("FAIL basic_slot%0d got none required %b", rd - ob, e); end
            else if (obs_mem[rd] !== e) begin n_fail++; $display("FAIL basic_slot%0d got %b required %b", rd - ob, obs_mem[rd], e); end
            rd++;
        end
        n_checks++; if (obs_n != rd) begin n_fail++; $display("FAIL basic_slot_count got %0d required %0d", obs_n - ob, rd - ob); end
        n_checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin n_fail++; $display("FAIL basic_start_stop got %0d/%0d required 1/1", start_cnt - s0, stop_cnt - p0); end
        n_checks++; if (rise_n - rb != 19) begin n_fail++; $display("FAIL basic_scl_pulses got %0d required 19", rise_n - rb); end
        for (int i = rb + 1; i < rise_n && i < rb + 19; i++) begin
            n_checks++;
            if (rise_mem[i] - rise_mem[i-1] != 16) begin n_fail++; $display("FAIL basic_scl_period%0d got %0d required 16", i - rb, rise_mem[i] - rise_mem[i-1]); end
        end
    endtask

    task automatic test_addr_nack;
        int n, rd, ob, rb;
        logic e;
        sel = 1'b0; nack_data = 1'b0;
        ob = obs_n; rb = rise_n;
        push_frame(7'h2A, 8'hFF, 1'b1, 1'b0);
        kick(1'b0, 7'h2A, 8'hFF);
        wait_done(1'b0, 400, n);
        n_checks++; if (n != 176) begin n_fail++; $display("FAIL anack_done_latency got %0d required 176", n); end
        n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL anack_ack_err got %b required 1", ack_a); end
        n_checks++; if (rise_n - rb != 10) begin n_fail++; $display("FAIL anack_scl_pulses got %0d required 10", rise_n - rb); end
        rd = ob;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rd >= obs_n) begin n_fail++; $display("FAIL anack_slot%0d got none required %b", rd - ob, e); end
            else if (obs_mem[rd] !== e) begin n_fail++; $display("FAIL anack_slot%0d got %b required %b", rd - ob, obs_mem[rd], e); end
            rd++;
        end
        n_checks++; if (obs_n != rd) begin n_fail++; $display("FAIL anack_slot_count got %0d required %0d", obs_n - ob, rd - ob); end
    endtask

    task automatic test_data_nack;
        int n, rd, ob, rb;
        logic e;
        sel = 1'b0; nack_data = 1'b1;
        ob = obs_n; rb = rise_n;
        push_frame(7'h55, 8'h5A, 1'b0, 1'b1);
        kick(1'b0, 7'h55, 8'h5A);
        wait_done(1'b0, 400, n);
        n_checks++; if (n != 320) begin n_fail++; $display("FAIL dnack_done_latency got %0d required 320", n); end
        n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL dnack_ack_err got %b required 1", ack_a); end
        n_checks++; if (rise_n - rb != 19) begin n_fail++; $display("FAIL dnack_scl_pulses got %0d required 19", rise_n - rb); end
        rd = ob;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rd >= obs_n) begin n_fail++; $display("FAIL dnack_slot%0d got none required %b", rd - ob, e); end
            else if (obs_mem[rd] !== e) begin n_fail++; $display("FAIL dnack_slot%0d got %b required %b", rd - ob, obs_mem[rd], e); end
            rd++;
        end
        n_checks++; if (obs_n != rd) begin n_fail++; $display("FAIL dnack_slot_count got %0d required %0d", obs_n - ob, rd - ob); end
        nack_data = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n, rd, ob, s0, p0;
        logic e;
        sel = 1'b0; nack_data = 1'b1;
        ob = obs_n; s0 = start_cnt; p0 = stop_cnt;
        push_frame(7'h55, 8'h0F, 1'b0, 1'b1);
        kick(1'b0, 7'h55, 8'h0F);
        n = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (i == 100) begin
                n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_at_100 got %b required 1", busy_a); end
                start_a = 1'b1; addr_a = 7'h2A; data_a = 8'h00;
            end
            if (i == 101) start_a = 1'b0;
            if (done_a) begin n = i; break; end
        end
        n_checks++; if (n != 320) begin n_fail++; $display("FAIL b2b_first_done got %0d required 320", n); end
        n_checks++; if (ack_a !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ack_err got %b required 1", ack_a); end
        nack_data = 1'b0;
        push_frame(7'h55, 8'hC3, 1'b0, 1'b0);
        kick(1'b0, 7'h55, 8'hC3);
        n_checks++; if (ack_a !== 1'b0 || busy_a !== 1'b1 || done_a !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_on_done got ack_err=%b busy=%b done=%b required 0 1 0", ack_a, busy_a, done_a); end
        wait_done(1'b0, 400, n);
        n_checks++; if (n != 320) begin n_fail++; $display("FAIL b2b_second_done got %0d required 320", n); end
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL b2b_second_ack_err got %b required 0", ack_a); end
        rd = ob;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rd >= obs_n) begin n_fail++; $display("FAIL b2b_slot%0d got none required %b", rd - ob, e); end
            else if (obs_mem[rd] !== e) begin n_fail++; $display("FAIL b2b_slot%0d got %b required %b", rd - ob, obs_mem[rd], e); end
            rd++;
        end
        n_checks++; if (obs_n != rd) begin n_fail++; $display("FAIL b2b_slot_count got %0d required %0d", obs_n - ob, rd - ob); end
        n_checks++; if (start_cnt - s0 != 2 || stop_cnt - p0 != 2) begin n_fail++; $display("FAIL b2b_start_stop got %0d/%0d required 2/2", start_cnt - s0, stop_cnt - p0); end
    endtask

    task automatic test_reset_mid_data;
        int n, rd, ob;
        logic e;
        sel = 1'b0; nack_data = 1'b0;
        kick(1'b0, 7'h55, 8'h96);
        repeat (200) @(posedge clk);
        #1;
        n_checks++; if (sda_a !== 1'b0 || busy_a !== 1'b1) begin n_fail++; $display("FAIL rst_pre got sda=%b busy=%b required 0 1", sda_a, busy_a); end
        rst = 1'b1;
        #1;
        n_checks++; if (sda_a !== 1'b1 || scl_a !== 1'b1) begin n_fail++; $display("FAIL rst_async_bus got sda=%b scl=%b required 1 1", sda_a, scl_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b required 0", busy_a); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ob = obs_n;
        push_frame(7'h55, 8'h3C, 1'b0, 1'b0);
        kick(1'b0, 7'h55, 8'h3C);
        wait_done(1'b0, 400, n);
        n_checks++; if (n != 320) begin n_fail++; $display("FAIL rst_recover_done got %0d required 320", n); end
        n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL rst_recover_ack_err got %b required 0", ack_a); end
        rd = ob;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rd >= obs_n) begin n_fail++; $display("FAIL rst_slot%0d got none required %b", rd - ob, e); end
            else if (obs_mem[rd] !== e) begin n_fail++; $display("FAIL rst_slot%0d got %b required %b", rd - ob, obs_mem[rd], e); end
            rd++;
        end
        n_checks++; if (obs_n != rd) begin n_fail++; $display("FAIL rst_slot_count got %0d required %0d", obs_n - ob, rd - ob); end
    endtask

    task automatic test_clkdiv1;
        int n, rd, ob, rb;
        logic e;
        sel = 1'b1; nack_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ob = obs_n; rb = rise_n;
        push_frame(7'h55, 8'hA5, 1'b0, 1'b0);
        kick(1'b1, 7'h55, 8'hA5);
        wait_done(1'b1, 200, n);
        n_checks++; if (n != 80) begin n_fail++; $display("FAIL div1_done_latency got %0d required 80", n); end
        n_checks++; if (ack_b !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL div1_status got ack_err=%b busy=%b required 0 0", ack_b, busy_b); end
        n_checks++; if (rise_n - rb != 19) begin n_fail++; $display("FAIL div1_scl_pulses got %0d required 19", rise_n - rb); end
        for (int i = rb + 1; i < rise_n && i < rb + 19; i++) begin
            n_checks++;
            if (rise_mem[i] - rise_mem[i-1] != 4) begin n_fail++; $display("FAIL div1_scl_period%0d got %0d required 4", i - rb, rise_mem[i] - rise_mem[i-1]); end
        end
        rd = ob;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (rd >= obs_n) begin n_fail++; $display("FAIL div1_slot%0d got none required %b", rd - ob, e); end
            else if (obs_mem[rd] !== e) begin n_fail++; $display("FAIL div1_slot%0d got %b required %b", rd - ob, obs_mem[rd], e); end
            rd++;
        end
        n_checks++; if (obs_n != rd) begin n_fail++; $display("FAIL div1_slot_count got %0d required %0d", obs_n - ob, rd - ob); end
        sel = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_addr_nack();
        test_data_nack();
        test_back_to_back();
        test_reset_mid_data();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_write.md
# i2c_master_write

Single-master I2C write initiator. It accepts a 7-bit target address and one data byte, then drives a complete write frame onto the open-drain bus: START, address with R/W=0, ACK check, data byte, ACK check, STOP. It is the initiator-side counterpart of the team's I2C slave receiver, and it sits between the register interface and the board-level SDA/SCL pads.

## Interface
Parameters:
- CLK_DIV, default 4: number of clk cycles per SCL quarter-period. One SCL bit is 4*CLK_DIV cycles. Legal range is 1 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request; accepted only when busy=0
- addr  in  7  target address; latched when start is accepted
- data  in  8  write byte; latched when start is accepted
- busy  out  1  high from the cycle after acceptance until the frame completes
- done  out  1  one-cycle pulse at end of frame
- ack_err  out  1  NACK seen in the last frame; held until the next acceptance
- sda  inout  1  open-drain: drives 0 or high-Z, never drives 1
- scl  inout  1  open-drain: drives 0 or high-Z; no clock-stretching support

## Operation
- **Reset values:** busy=0, done=0, ack_err=0, sda=Z, scl=Z, state=IDLE.
  - Reset is asynchronous: asserting rst mid-frame releases both lines immediately and returns to IDLE.
  - No STOP is generated on reset.
- **Acceptance:** at a clk edge with start=1 and busy=0:
  - latch addr and data;
  - load shift register = {addr, 1'b0};
  - clear ack_err;
  - enter START.
  - start while busy=1 is ignored.
- **Quarter timer:** counts 0..CLK_DIV-1. On wrap it advances the quarter index q (0..3). Every non-IDLE state lasts 4 quarters.
- **FSM states:** IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
- **START:**
  - q0–q1: SCL=Z, SDA=Z.
  - q2–q3: SCL=Z, SDA=0. This SDA fall while SCL is high is the START condition.
  - Then enter ADDR with bit counter = 7.
- **Bit slot** (ADDR, DATA, and both ACK states):
  - q0–q1: SCL=0. SDA is set at the start of q0 (MSB first, a 1 released as Z).
  - q2–q3: SCL=Z.
  - SDA is held stable for the whole slot.
- **ADDR:** 8 slots (7 address bits, then R/W=0). After the last slot, enter ADDR_ACK.
- **ACK slots:**
  - SDA=Z for the whole slot.
  - SDA is sampled on the last clk cycle of q2.
  - A sampled 1 is a NACK and sets ack_err=1.
- **ADDR_ACK:**
  - NACK: enter STOP; no data bits are sent.
  - ACK: load the shift register with data and enter DATA.
- **DATA:** 8 slots, then DATA_ACK.
- **DATA_ACK:** enter STOP regardless of the ACK result (ack_err is set on NACK).
- **STOP:**
  - q0–q1: SCL=0, SDA=0.
  - q2: SCL=Z, SDA=0.
  - q3: SCL=Z, SDA=Z. This SDA rise while SCL is high is the STOP condition.
  - Then enter IDLE.
- **Entering IDLE from STOP:** busy=0 and done=1 for exactly one cycle. A start in that same cycle is accepted.
- **Bus arbitration:** none; the block assumes it is the only master.
- **Read-back:** the block never samples SDA other than in the ACK slots.

## Timing
- busy rises on the clk edge after acceptance.
- Full frame: START 4 + ADDR 32 + ADDR_ACK 4 + DATA 32 + DATA_ACK 4 + STOP 4 = 80 quarters. done is high 80*CLK_DIV cycles after the accepting edge.
- Address-NACK frame: 4 + 32 + 4 + 4 = 44 quarters. done is high 44*CLK_DIV cycles after acceptance.
- SCL period is 4*CLK_DIV cycles with 50% duty. SDA never changes while SCL is released, except at START and STOP.
- Back-to-back frames: the minimum gap between STOP end and the next START's SDA fall is 2 quarters (START q0–q1 bus-free time).
- ack_err updates on the clk edge following the sample cycle.

## Test plan
- **Basic write:** CLK_DIV=4, pull-ups on the bus, slave model at 0x55 ACKing; start with addr=0x55, data=0xA5.
  - SDA slots read 1010101, 0, ACK, 10100101, ACK.
  - START and STOP conditions are present.
  - done is high 320 cycles after acceptance; ack_err=0; busy low in the done cycle.
- **Address NACK:** start with addr=0x2A against a 0x55-only slave.
  - ack_err=1; no SCL pulses after the ADDR_ACK slot except the STOP.
  - done at 176 cycles.
- **Data NACK:** slave ACKs the address and NACKs the data.
  - All 18 slots are run; ack_err=1; done at 320 cycles.
- **Start during busy, and start on done:**
  - Assert start at cycle 100 of a frame: ignored, latched addr/data unchanged.
  - Assert start in the done cycle: accepted; the second frame's START follows, and ack_err is cleared at acceptance.
- **Reset mid-DATA:** assert rst at cycle 200.
  - sda and scl go Z and busy=0 without waiting for a clk edge.
  - After release, a new start (addr=0x55, data=0x3C) completes normally.
- **CLK_DIV=1:** basic write completes in 80 cycles with SCL period 4 cycles; the bit pattern matches the basic-write case.
